ps2_receiver: RTL and testbench

PS/2 serial front end for the keyboard path. It synchronises and deglitches the raw `ps2_clk`/`ps2_data` pins and deserialises the 11-bit device-to-host frames. For each valid frame it presents the 8-bit scan code on `dout` with a one-cycle `rx_done_tick`. It sits directly upstream of `keyboard_decode`, which consumes `dout` and `rx_done_tick` unchanged.

---
 rtl/ps2_receiver_if.sv | 20 ++
 rtl/ps2_receiver.sv | 127 ++++++++++++
 tb/tb_ps2_receiver.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ps2_receiver_if.sv
// PS/2 receiver bundle: raw pins and enable in, scan code and status pulses out.
interface ps2_receiver_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic       rx_en;
  logic       rx_done_tick;
  logic [7:0] dout;
  logic       frame_err;
  logic       parity_err;

  modport master (
    output ps2_clk, ps2_data, rx_en,
    input  rx_done_tick, dout, frame_err, parity_err
  );

  modport slave (
    input  ps2_clk, ps2_data, rx_en,
    output rx_done_tick, dout, frame_err, parity_err
  );
endinterface

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host receiver: pin sync, clock deglitch filter, 11-bit frame deserialiser.
// Define PS2_PARITY_CHECK_EN to check odd parity and drop bad-parity frames.
module ps2_receiver #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 65000
) (
  input  logic           clk,
  input  logic           rst,
  ps2_receiver_if.slave  bus
);

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PARITY_CHECK = 1'b1;
`else
  localparam bit PARITY_CHECK = 1'b0;
`endif

  localparam int unsigned TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  logic [1:0]            clk_sync;
  logic [1:0]            data_sync;
  logic [FILTER_LEN-1:0] filt;
  logic                  f_clk;
  logic                  f_clk_q;
  logic                  fall_edge;
  logic                  data_s;

  state_t                state;
  logic [3:0]            bit_cnt;
  logic [9:0]            shreg;
  logic [TW-1:0]         tcnt;
  logic [7:0]            dout_r;
  logic                  tick_r;
  logic                  ferr_r;
  logic                  perr_r;
  logic                  parity_ok;

  // Pins idle high, so every stage resets to 1 to avoid a spurious edge out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      filt      <= '1;
      f_clk     <= 1'b1;
      f_clk_q   <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], bus.ps2_clk};
      data_sync <= {data_sync[0], bus.ps2_data};
      filt      <= {filt[FILTER_LEN-2:0], clk_sync[1]};
      if (filt == '1)
        f_clk <= 1'b1;
      else if (filt == '0)
        f_clk <= 1'b0;
      f_clk_q   <= f_clk;
    end
  end

  assign fall_edge = f_clk_q & ~f_clk;
  assign data_s    = data_sync[1];
  assign parity_ok = ^shreg[8:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      tcnt    <= '0;
      dout_r  <= '0;
      tick_r  <= 1'b0;
      ferr_r  <= 1'b0;
      perr_r  <= 1'b0;
    end else begin
      tick_r <= 1'b0;
      ferr_r <= 1'b0;
      perr_r <= 1'b0;
      case (state)
        IDLE: begin
          if (fall_edge && bus.rx_en && !data_s) begin
            state   <= RECV;
            bit_cnt <= 4'd9;
            tcnt    <= '0;
          end
        end
        RECV: begin
          if (fall_edge) begin
            shreg <= {data_s, shreg[9:1]};
            tcnt  <= '0;
            if (bit_cnt == 4'd0)
              state <= DONE;
            else
              bit_cnt <= bit_cnt - 4'd1;
          end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
            state  <= IDLE;
            ferr_r <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        DONE: begin
          // A bad stop bit takes precedence over a parity failure.
          state <= IDLE;
          if (!shreg[9]) begin
            ferr_r <= 1'b1;
          end else if (PARITY_CHECK && !parity_ok) begin
            perr_r <= 1'b1;
          end else begin
            tick_r <= 1'b1;
            dout_r <= shreg[7:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rx_done_tick = tick_r;
  assign bus.dout         = dout_r;
  assign bus.frame_err    = ferr_r;
`ifdef PS2_PARITY_CHECK_EN
  assign bus.parity_err   = perr_r;
`else
  assign bus.parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_receiver.sv
// Bench for ps2_receiver: table of frames plus hand-written corner sequences, scoreboard of output events.
module tb_ps2_receiver;

  localparam int H = 20;
  localparam int LAT = 13;
  localparam logic [2:0] K_TICK = 3'b100;
  localparam logic [2:0] K_FERR = 3'b010;
  localparam logic [2:0] K_PERR = 3'b001;

`ifdef PS2_PARITY_CHECK_EN
  localparam logic [2:0] K_V2 = K_PERR;
  localparam logic [7:0] D_V2 = 8'hF0;
`else
  localparam logic [2:0] K_V2 = K_TICK;
  localparam logic [7:0] D_V2 = 8'h1C;
`endif

  typedef struct {
    logic [2:0] kind;
    logic [7:0] data;
    int         lat;
    int         tol;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic [2:0] kind;
    logic [7:0] dout;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   last_fall = 0;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_dout = 8'h00;
  exp_t exp_q[$];
  vec_t vecs[8];

  ps2_receiver_if bus();

  ps2_receiver #(.FILTER_LEN(8), .TIMEOUT_CYC(1000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    logic [2:0] obs;
    exp_t e;
    int got;
    if (!rst && (bus.rx_done_tick || bus.frame_err || bus.parity_err)) begin
      obs = {bus.rx_done_tick, bus.frame_err, bus.parity_err};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got kind %b dout %h, required no event", obs, bus.dout);
      end else begin
        e = exp_q.pop_front();
        got = cyc - last_fall;
        if (obs !== e.kind) begin
          errors++;
          $display("FAIL event_kind: got %b, required %b", obs, e.kind);
        end
        checks++;
        if (bus.dout !== e.data) begin
          errors++;
          $display("FAIL event_dout: got %h, required %h", bus.dout, e.data);
        end
        checks++;
        if (got < e.lat - e.tol || got > e.lat + e.tol) begin
          errors++;
          $display("FAIL event_latency: got %0d, required %0d +/- %0d", got, e.lat, e.tol);
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    bus.ps2_data = b;
    wait_cycles(H);
    bus.ps2_clk = 1'b0;
    last_fall = cyc;
    wait_cycles(H);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int nbits, input bit drop_en);
    logic [10:0] bits;
    bits = {stop, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      send_bit(bits[i]);
      if (i == 0 && drop_en) bus.rx_en = 1'b0;
    end
    bus.ps2_data = 1'b1;
  endtask

  task automatic push(input logic [2:0] kind, input logic [7:0] d, input int lat, input int tol);
    exp_t e;
    e.kind = kind;
    e.data = d;
    e.lat  = lat;
    e.tol  = tol;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({bus.dout, bus.rx_done_tick, bus.frame_err, bus.parity_err} !== 11'h000) begin
      errors++;
      $display("FAIL %s: got dout %h tick %b ferr %b perr %b, required all zero",
               name, bus.dout, bus.rx_done_tick, bus.frame_err, bus.parity_err);
    end
  endtask

  task automatic good_frame(input logic [7:0] d, input logic par, input bit drop_en);
    push(K_TICK, d, LAT, 0);
    exp_dout = d;
    send_frame(d, par, 1'b1, 11, drop_en);
    wait_cycles(40);
  endtask

  initial begin
    vecs[0] = '{8'h1C, 1'b0, 1'b1, K_TICK, 8'h1C};
    vecs[1] = '{8'hF0, 1'b1, 1'b1, K_TICK, 8'hF0};
    vecs[2] = '{8'h1C, 1'b1, 1'b1, K_V2,   D_V2};
    vecs[3] = '{8'h23, 1'b0, 1'b0, K_FERR, D_V2};
    vecs[4] = '{8'h5A, 1'b1, 1'b1, K_TICK, 8'h5A};
    vecs[5] = '{8'h00, 1'b1, 1'b1, K_TICK, 8'h00};
    vecs[6] = '{8'hFF, 1'b1, 1'b1, K_TICK, 8'hFF};
    vecs[7] = '{8'h23, 1'b1, 1'b0, K_FERR, 8'hFF};

    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    bus.rx_en    = 1'b1;
    rst = 1'b1;
    wait_cycles(5);
    check_reset_outputs("reset_state");
    rst = 1'b0;
    wait_cycles(30);

    foreach (vecs[i]) begin
      push(vecs[i].kind, vecs[i].dout, LAT, 0);
      send_frame(vecs[i].data, vecs[i].par, vecs[i].stop, 11, 1'b0);
      wait_cycles(40);
    end
    exp_dout = vecs[7].dout;

    // Timeout: clock stops after start + 4 data bits.
    push(K_FERR, exp_dout, 1012, 3);
    send_frame(8'h1D, 1'b1, 1'b1, 5, 1'b0);
    wait_cycles(1100);
    good_frame(8'h1D, 1'b1, 1'b0);

    // 3-cycle glitch with data low must not start a frame.
    bus.ps2_data = 1'b0;
    wait_cycles(H);
    bus.ps2_clk = 1'b0;
    wait_cycles(3);
    bus.ps2_clk = 1'b1;
    wait_cycles(40);
    bus.ps2_data = 1'b1;
    wait_cycles(H);
    good_frame(8'h33, 1'b1, 1'b0);

    // Frame with rx_en low is ignored entirely.
    bus.rx_en = 1'b0;
    send_frame(8'h44, 1'b1, 1'b1, 11, 1'b0);
    wait_cycles(40);
    checks++;
    if (bus.dout !== exp_dout) begin
      errors++;
      $display("FAIL rx_en_low_dout: got %h, required %h", bus.dout, exp_dout);
    end
    bus.rx_en = 1'b1;

    // rx_en dropped after the start bit: frame still completes.
    good_frame(8'h29, 1'b0, 1'b1);
    bus.rx_en = 1'b1;

    // Reset mid-frame discards the partial frame silently.
    send_frame(8'h76, 1'b0, 1'b1, 6, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_cycles(1);
      check_reset_outputs("reset_mid_frame");
    end
    exp_dout = 8'h00;
    rst = 1'b0;
    wait_cycles(40);
    good_frame(8'h76, 1'b0, 1'b0);

    wait_cycles(100);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d outstanding, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
